// File: rtl/prince_sbox_cms_pipe.sv
// Two-share CMS-masked PRINCE S-box layer with a 2-stage elastic pipeline.
// Stage 1 registers 8 ring-refreshed, non-complete component shares for each
// output bit. Stage 2 compresses them back to 2 shares.

// Per-S-box expansion and refresh (combinational).
// Domain k takes one share of each variable. The share selection is
// {x,y,z,w} = {k[2], k[1], k[0], k[2]^k[1]^k[0]}. Its projection onto any three
// variables is a bijection, so every share combination of every monomial of
// degree <= 3 lands in exactly one canonical domain. When several domains
// match, the priority order is 0, then 7, then 1..6 ascending. This puts the
// constant and all share-0 linear terms in domain 0 and all share-1 linear
// terms in domain 7.
module prince_cms_lane (
  input  logic [3:0]  i_sh0,
  input  logic [3:0]  i_sh1,
  input  logic [31:0] i_rnd,
  output logic [31:0] o_e
);

  // Share selector of domain k, in nibble bit order {x,y,z,w}
  function automatic logic [3:0] f_sel(input int k);
    logic [2:0] kk;
    kk = 3'(k);
    return {kk[2], kk[1], kk[0], ^kk};
  endfunction

  // ANF of each output coordinate, obtained by a Moebius transform of the table
  function automatic logic [3:0][15:0] f_anf();
    logic [15:0][3:0] sb;
    logic [3:0][15:0] a;
    sb = {4'h4, 4'hD, 4'h5, 4'hE, 4'h0, 4'h8, 4'h7, 4'h6,
          4'h1, 4'h9, 4'hC, 4'hA, 4'h2, 4'h3, 4'hF, 4'hB};
    for (int b = 0; b < 4; b++) begin
      for (int m = 0; m < 16; m++) a[b][m] = sb[m][b];
      for (int j = 0; j < 4; j++)
        for (int m = 0; m < 16; m++)
          if (((m >> j) & 1) == 1) a[b][m] = a[b][m] ^ a[b][m ^ (1 << j)];
    end
    return a;
  endfunction

  // canon[k][m]: domain k owns monomial m for its share-combination projection
  function automatic logic [7:0][15:0] f_canon();
    logic [7:0][15:0] c;
    logic [3:0]       mm;
    logic [3:0]       proj;
    logic             hi;
    for (int k = 0; k < 8; k++)
      for (int m = 0; m < 16; m++) begin
        mm      = 4'(m);
        proj    = f_sel(k) & mm;
        c[k][m] = 1'b1;
        for (int kp = 0; kp < 8; kp++) begin
          hi = (kp == 0 && k != 0) ||
               (kp == 7 && k >= 1 && k <= 6) ||
               (kp >= 1 && kp < k && k <= 6);
          if (hi && ((f_sel(kp) & mm) == proj)) c[k][m] = 1'b0;
        end
      end
    return c;
  endfunction

  localparam logic [3:0][15:0] ANF   = f_anf();
  localparam logic [7:0][15:0] CANON = f_canon();

  // Expand each output bit into 8 domains and apply the ring refresh
  always_comb begin
    logic [3:0] w_dom;
    logic [3:0] w_sel;
    logic [3:0] w_m;
    logic       w_acc;
    o_e = '0;
    for (int k = 0; k < 8; k++) begin
      w_sel = f_sel(k);
      w_dom = (w_sel & i_sh1) | (~w_sel & i_sh0);
      for (int b = 0; b < 4; b++) begin
        w_acc = 1'b0;
        for (int m = 0; m < 16; m++) begin
          w_m = 4'(m);
          if (ANF[b][m] && CANON[k][m] && ((w_dom & w_m) == w_m))
            w_acc = ~w_acc;
        end
        o_e[b*8 + k] = w_acc ^ i_rnd[b*8 + k] ^ i_rnd[b*8 + ((k + 7) % 8)];
      end
    end
  end

endmodule

module prince_sbox_cms_pipe #(
  parameter int NSBOX = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [4*NSBOX-1:0]    i_in_sh0,
  input  logic [4*NSBOX-1:0]    i_in_sh1,
  input  logic [32*NSBOX-1:0]   i_rnd,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [4*NSBOX-1:0]    o_out_sh0,
  output logic [4*NSBOX-1:0]    o_out_sh1
);

  localparam int STAGES = 2;

  logic [NSBOX-1:0][31:0] w_e;
  logic [NSBOX-1:0][31:0] r_s1;
  logic [NSBOX-1:0][3:0]  w_cmp0, w_cmp1;
  logic [NSBOX-1:0][3:0]  r_out0, r_out1;
  logic [STAGES:1]        r_vld_pipe;
  logic                   w_en1, w_en2;

  // A stage may load when it is empty or the stage after it is moving
  assign w_en2      = ~r_vld_pipe[2] | i_out_ready;
  assign w_en1      = ~r_vld_pipe[1] | w_en2;
  assign o_in_ready = w_en1;

  for (genvar i = 0; i < NSBOX; i++) begin : g_lane
    prince_cms_lane u_lane (
      .i_sh0 (i_in_sh0[i*4 +: 4]),
      .i_sh1 (i_in_sh1[i*4 +: 4]),
      .i_rnd (i_rnd[i*32 +: 32]),
      .o_e   (w_e[i])
    );
    for (genvar b = 0; b < 4; b++) begin : g_bit
      assign w_cmp0[i][b] = ^r_s1[i][b*8 +: 4];
      assign w_cmp1[i][b] = ^r_s1[i][b*8 + 4 +: 4];
    end
  end

  // Valid pipe: each bit moves only with its stage enable, bubbles carry 0
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_vld_pipe <= '0;
    end else begin
      if (w_en1) r_vld_pipe[1] <= i_in_valid;
      if (w_en2) r_vld_pipe[2] <= r_vld_pipe[1];
    end
  end

  // Stage 1: glitch barrier on the refreshed component shares
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_s1 <= '0;
    else if (w_en1) r_s1 <= w_e;
  end

  // Stage 2: compressed output shares, held while downstream stalls
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_out0 <= '0;
      r_out1 <= '0;
    end else if (w_en2) begin
      r_out0 <= w_cmp0;
      r_out1 <= w_cmp1;
    end
  end

  assign o_out_valid = r_vld_pipe[2];
  assign o_out_sh0   = r_out0;
  assign o_out_sh1   = r_out1;

endmodule

// File: tb/tb_prince_sbox_cms_pipe.sv
// Scoreboard bench: the driver pushes the expected unmasked S-box output of
// each accepted beat, and the monitor pops and compares on every transfer.
module tb_prince_sbox_cms_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, in_valid, out_ready, in_ready, o_valid;
  logic [63:0]  in_sh0, in_sh1, o_sh0, o_sh1;
  logic [511:0] rnd;

  logic         d1_in_valid, d1_in_ready, d1_o_valid;
  logic [3:0]   d1_sh0, d1_sh1, d1_o0, d1_o1;
  logic [31:0]  d1_rnd;

  prince_sbox_cms_pipe #(.NSBOX(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_sh0(in_sh0), .i_in_sh1(in_sh1), .i_rnd(rnd),
    .o_out_valid(o_valid), .i_out_ready(out_ready),
    .o_out_sh0(o_sh0), .o_out_sh1(o_sh1));

  prince_sbox_cms_pipe #(.NSBOX(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(d1_in_valid), .o_in_ready(d1_in_ready),
    .i_in_sh0(d1_sh0), .i_in_sh1(d1_sh1), .i_rnd(d1_rnd),
    .o_out_valid(d1_o_valid), .i_out_ready(1'b1),
    .o_out_sh0(d1_o0), .o_out_sh1(d1_o1));

  localparam logic [3:0] SBOX [16] = '{4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
                                       4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4};

  int n_checks = 0, n_errors = 0;
  int cyc = 0;
  logic [63:0] sb[$];
  logic [63:0] obs[$];
  logic        held_vld = 1'b0, saw_full = 1'b0;
  logic [63:0] h0, h1;
  logic        first_push = 1'b0, first_out = 1'b0;
  int          t_push = 0, t_out = 0, n_valid_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] sbox16(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = SBOX[v[i*4 +: 4]];
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Offer one beat until accepted; push its expected value at acceptance
  task automatic send(input logic [63:0] v, input logic [511:0] r);
    int n;
    logic [63:0] s1;
    s1 = rand64();
    in_sh1 = s1;
    in_sh0 = v ^ s1;
    rnd = r;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL accept_timeout: in_ready stuck low for value %h", v);
    end else begin
      sb.push_back(sbox16(v));
      if (!first_push) begin
        first_push = 1'b1;
        t_push = cyc;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: score transfers, check stability while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (o_valid && out_ready) begin
        held_vld = 1'b0;
        n_valid_seen++;
        obs.push_back(o_sh0);
        if (!first_out) begin
          first_out = 1'b1;
          t_out = cyc;
        end
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL beat: unexpected output %h, nothing expected", o_sh0 ^ o_sh1);
        end else begin
          chk("beat", o_sh0 ^ o_sh1, sb.pop_front());
        end
      end else if (o_valid) begin
        if (held_vld) begin
          chk("hold_sh0", o_sh0, h0);
          chk("hold_sh1", o_sh1, h1);
        end
        held_vld = 1'b1;
        h0 = o_sh0;
        h1 = o_sh1;
      end else begin
        held_vld = 1'b0;
      end
      if (!in_ready) saw_full = 1'b1;
    end
  end

  initial begin
    logic [63:0] v;
    logic        differ;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_sh0 = '0; in_sh1 = '0; rnd = '0;
    d1_in_valid = 1'b0; d1_sh0 = '0; d1_sh1 = '0; d1_rnd = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", 64'(o_valid), 64'd0);
    chk("reset_out_sh", o_sh0 | o_sh1, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // All 16 values in every lane (beat 0 is nibble i = i), back to back
    for (int j = 0; j < 16; j++) begin
      for (int i = 0; i < 16; i++) v[i*4 +: 4] = 4'((j + i) & 15);
      send(v, rand512());
    end
    repeat (4) @(posedge clk);
    #1;
    chk("latency", 64'(t_out - t_push), 64'd2);

    // Same input under zero, all-ones and random refresh masks
    obs.delete();
    send({16{4'h3}}, '0);
    send({16{4'h3}}, '1);
    send({16{4'h3}}, rand512());
    send({16{4'h3}}, rand512());
    repeat (4) @(posedge clk);
    #1;
    differ = (obs.size() == 4) && (obs[2] !== obs[3]);
    chk("share_varies", 64'(differ), 64'd1);

    // Backpressure: 6 beats with out_ready low for 3 cycles mid-stream
    saw_full = 1'b0;
    fork
      begin
        for (int j = 0; j < 6; j++) send({16{4'(j + 7)}}, rand512());
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("in_ready_dropped", 64'(saw_full), 64'd1);
    chk("sb_drained_bp", 64'(sb.size()), 64'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    send({16{4'hA}}, rand512());
    send({16{4'h5}}, rand512());
    rst_n = 1'b0;
    @(negedge clk);
    chk("fill_before_reset", 64'(o_valid), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_out_valid", 64'(o_valid), 64'd0);
    chk("midrst_out_sh", o_sh0 | o_sh1, 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    n_valid_seen = 0;
    repeat (5) @(negedge clk);
    chk("no_stale_beat", 64'(n_valid_seen), 64'd0);

    // Single S-box instance, one beat at a time
    for (int j = 0; j < 16; j++) begin
      @(posedge clk);
      #1;
      d1_sh1 = 4'($urandom);
      d1_sh0 = 4'(j) ^ d1_sh1;
      d1_rnd = $urandom;
      d1_in_valid = 1'b1;
      @(posedge clk);
      #1 d1_in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("nsbox1", {59'd0, d1_o_valid, d1_o0 ^ d1_o1}, {59'd0, 1'b1, SBOX[j]});
    end

    chk("sb_final_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
